// File: rtl/bcd_sweep_ctrl.sv
// Two-digit BCD sweep counter with bounce, up-wrap, down-wrap and one-shot modes.
// The counter advances once every TICK_DIV clocks while the FSM is in UP or DOWN.
module bcd_sweep_ctrl #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned TOP_TENS = 3,
  parameter int unsigned TOP_ONES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic [1:0] mode,
  output logic [3:0] q1,
  output logic [3:0] q0,
  output logic       direction,
  output logic       running,
  output logic       step,
  output logic       done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UP,
    ST_DOWN,
    ST_PAUSED,
    ST_DONE
  } state_t;

  localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);
  localparam logic [7:0] TOP        = {4'(TOP_TENS), 4'(TOP_ONES)};

  localparam logic [1:0] MODE_BOUNCE  = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [7:0] presc_q, presc_d;
  logic       dir_q, dir_d;
  logic [1:0] mode_q, mode_d;
  logic       step_q, step_d;
  logic       done_q, done_d;
  logic       tick;
  logic [7:0] nxt;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign tick = ((state_q == ST_UP) || (state_q == ST_DOWN)) && (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    nxt     = count_q;

    if (stop) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else if (start) begin
      mode_d  = mode;
      presc_d = '0;
      if (mode == MODE_DOWN) begin
        count_d = TOP;
        dir_d   = 1'b0;
        state_d = ST_DOWN;
      end else begin
        count_d = '0;
        dir_d   = 1'b1;
        state_d = ST_UP;
      end
    end else begin
      case (state_q)
        ST_UP, ST_DOWN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (!tick) begin
            presc_d = presc_q + 8'd1;
          end else begin
            presc_d = '0;
            step_d  = 1'b1;
            if (state_q == ST_UP) begin
              if (count_q != TOP) begin
                nxt = bcd_inc(count_q);
              end else if (mode_q == MODE_BOUNCE) begin
                nxt     = bcd_dec(TOP);
                dir_d   = 1'b0;
                state_d = ST_DOWN;
              end else begin
                nxt = '0;
              end
              // One-shot finishes on the tick that lands on top, not one tick later.
              if ((mode_q == MODE_ONESHOT) && (nxt == TOP)) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
              end
            end else begin
              if (count_q != '0) begin
                nxt = bcd_dec(count_q);
              end else if (mode_q == MODE_BOUNCE) begin
                nxt     = 8'h01;
                dir_d   = 1'b1;
                state_d = ST_UP;
              end else begin
                nxt = TOP;
              end
            end
            count_d = nxt;
          end
        end
        ST_PAUSED: begin
          if (!pause) state_d = dir_q ? ST_UP : ST_DOWN;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      presc_q <= '0;
      dir_q   <= 1'b1;
      mode_q  <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  assign q1        = count_q[7:4];
  assign q0        = count_q[3:0];
  assign direction = dir_q;
  assign running   = (state_q == ST_UP) || (state_q == ST_DOWN);
  assign step      = step_q;
  assign done      = done_q;

endmodule

// File: doc/bcd_sweep_ctrl.md
BCD_SWEEP_CTRL -- requirements
Module: bcd_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 4: clk cycles per count step (legal range 1..255).
REQ-002 The block SHALL have parameter TOP_TENS, default 3: tens digit of the top value.
REQ-003 The block SHALL have parameter TOP_ONES, default 1: ones digit of the top value (default top = 31).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port start  input  1  level sampled each clock; (re)starts a sweep.
REQ-007 The block SHALL have port stop  input  1  abort; returns to IDLE and holds the count.
REQ-008 The block SHALL have port pause  input  1  while high, the running sweep freezes.
REQ-009 The block SHALL have port mode  input  2  00 bounce, 01 up-wrap, 10 down-wrap, 11 one-shot up; sampled only when start is accepted.
REQ-010 The block SHALL have ports q1 and q0  output  4 each  tens and ones BCD digits.
REQ-011 The block SHALL have port direction  output  1  1 = up, 0 = down.
REQ-012 The block SHALL have port running  output  1  high in states UP and DOWN.
REQ-013 The block SHALL have port step  output  1  one-cycle pulse on each cycle the count changes.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse when one-shot mode completes.

Function
REQ-015 The FSM SHALL have states IDLE, UP, DOWN, PAUSED and DONE; input priority SHALL be stop > start > pause.
REQ-016 Accepted start (any state) SHALL latch mode, clear the prescaler and load the count: 00 with direction 1 and state UP for modes 00/01/11; top with direction 0 and state DOWN for mode 10.
REQ-017 The prescaler SHALL count only in UP/DOWN and SHALL produce a tick every TICK_DIV cycles; the first step comes TICK_DIV cycles after start is accepted.
REQ-018 Each tick SHALL change the count by exactly one, in BCD: ones digit 9->0 with tens +1; 0->9 with tens -1; digits SHALL never leave 0..9.
REQ-019 Bounce: a tick at top in UP SHALL load top-1 and go to DOWN; a tick at 00 in DOWN SHALL load 01 and go to UP. The sequence is 00..top..00 with no repeated value.
REQ-020 Up-wrap: a tick at top SHALL load 00. Down-wrap: a tick at 00 SHALL load top.
REQ-021 One-shot: the tick that loads top SHALL move the FSM to DONE and pulse done in that same cycle; count holds top.
REQ-022 pause high in UP/DOWN SHALL enter PAUSED within one cycle with count and prescaler frozen; pause low SHALL resume the saved direction with the prescaler continuing from its frozen value.
REQ-023 stop SHALL go to IDLE within one cycle, hold the count and clear the prescaler.
REQ-024 running SHALL be high exactly in UP and DOWN; direction SHALL change only on start or a bounce reversal.
REQ-025 step SHALL pulse with every count change, including the change caused by a tick, but not on a start load.
REQ-026 A tick coinciding with stop or start SHALL be discarded.

Reset
REQ-027 reset SHALL asynchronously force IDLE, q1=0, q0=0, direction=1, running=0, step=0, done=0, prescaler=0 and latched mode=00.
REQ-028 reset asserted mid-sweep SHALL abort the sweep with no further step pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-029 TICK_DIV=4, mode 00, pulse start -> 01 appears 4 cycles later; the sequence 00..31,30..00,01 follows with direction falling at the 31->30 step.
REQ-030 Mode 01 -> after 31 comes 00; mode 10 -> start loads 31 and 00 is followed by 31; digits 09<->10 and 20<->19 are correct in both directions.
REQ-031 Mode 11 -> done pulses once as the count reaches 31; FSM stays in DONE; running=0; no further steps until a new start.
REQ-032 pause held 10 cycles mid-sweep -> no step pulse and q frozen; after release the next step occurs after the remaining prescaler cycles.
REQ-033 stop and start asserted together -> IDLE with count held; reset asserted mid-sweep -> outputs equal the REQ-027 values immediately, with no clock edge needed.
